// File: rtl/seq_match_datapath.sv
// -----------------------------------------------------------------------------
// seq_match_datapath
//
// Self-contained "repeat the growing sequence" engine: sequence ROM, address
// counter, round-limit counter, key register, equality comparator and the
// control FSM. Round k requires the player to enter ROM words 0..k in order.
//
// Optional feature: define TIMEOUT_EN to build an inactivity timeout in
// ESPERA. Without it, ESPERA waits forever, state 8 is unreachable and
// db_timeout is tied to 0.
//
// Parameters:
//   DATA_WIDTH     width of keys and ROM words
//   ADDR_WIDTH     ROM address width, DEPTH = 2**ADDR_WIDTH words/rounds
//   TIMEOUT_CYCLES cycles allowed in ESPERA without a play (TIMEOUT_EN only)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   iniciar      in   start/restart request, level-sampled
//   chaves       in   player keys (one-hot in normal use)
//   pronto       out  game finished (win, error or timeout)
//   acertou      out  whole sequence completed
//   errou        out  mismatch or timeout
//   db_contagem  out  current ROM address
//   db_limite    out  current round limit
//   db_chaves    out  registered key value
//   db_memoria   out  current ROM word (registered ROM output)
//   db_estado    out  FSM state code
//   db_timeout   out  timeout flag
//
// Handshake: there is no valid/ready pair. A play is the first cycle on which
// chaves is non-zero after a cycle on which it was zero; it is only consumed
// while the FSM is in ESPERA. iniciar is a level consumed in states 0, 6, 7, 8.
// -----------------------------------------------------------------------------
module seq_match_datapath #(
    parameter int DATA_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [DATA_WIDTH-1:0] chaves,
    output logic                  pronto,
    output logic                  acertou,
    output logic                  errou,
    output logic [ADDR_WIDTH-1:0] db_contagem,
    output logic [ADDR_WIDTH-1:0] db_limite,
    output logic [DATA_WIDTH-1:0] db_chaves,
    output logic [DATA_WIDTH-1:0] db_memoria,
    output logic [3:0]            db_estado,
    output logic                  db_timeout
);

    typedef enum logic [3:0] {
        S_INICIAL        = 4'd0,
        S_PREPARA        = 4'd1,
        S_ESPERA         = 4'd2,
        S_COMPARA        = 4'd3,
        S_PROXIMO        = 4'd4,
        S_PROXIMA_RODADA = 4'd5,
        S_ACERTO         = 4'd6,
        S_ERRO           = 4'd7,
        S_TIMEOUT        = 4'd8
    } state_t;

    // DEPTH-1 is the all-ones address: the last round and the last word.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] limit_q;
    logic [DATA_WIDTH-1:0] key_q;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] chaves_prev_q;
    logic                  pronto_q;
    logic                  acertou_q;
    logic                  errou_q;

    logic [DATA_WIDTH-1:0] rom_d;
    logic                  jogada_d;
    logic                  match_d;

    // Sequence contents: word i has a single bit set at position i mod DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(1) << (int'(a) % DATA_WIDTH);
    endfunction

    assign rom_d    = rom_word(addr_q);
    // Rising edge of "any key pressed": holding or sliding between keys
    // without a release never produces a second play.
    assign jogada_d = (chaves != '0) && (chaves_prev_q == '0);
    assign match_d  = (key_q == rom_q);

    // Synchronous ROM (1-cycle latency) and the key history for play detect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_q         <= '0;
            chaves_prev_q <= '0;
        end else begin
            rom_q         <= rom_d;
            chaves_prev_q <= chaves;
        end
    end

`ifdef TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_flag_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_INICIAL;
            addr_q     <= '0;
            limit_q    <= '0;
            key_q      <= '0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            errou_q    <= 1'b0;
`ifdef TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_INICIAL: begin
                    if (iniciar) state_q <= S_PREPARA;
                end
                S_PREPARA: begin
                    addr_q     <= '0;
                    limit_q    <= '0;
                    key_q      <= '0;
                    pronto_q   <= 1'b0;
                    acertou_q  <= 1'b0;
                    errou_q    <= 1'b0;
`ifdef TIMEOUT_EN
                    tmo_cnt_q  <= '0;
                    tmo_flag_q <= 1'b0;
`endif
                    state_q    <= S_ESPERA;
                end
                S_ESPERA: begin
                    // A play wins over an expiring timeout in the same cycle.
                    if (jogada_d) begin
                        key_q   <= chaves;
                        state_q <= S_COMPARA;
`ifdef TIMEOUT_EN
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        pronto_q   <= 1'b1;
                        errou_q    <= 1'b1;
                        tmo_flag_q <= 1'b1;
                        state_q    <= S_TIMEOUT;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                S_COMPARA: begin
                    if (!match_d) begin
                        pronto_q <= 1'b1;
                        errou_q  <= 1'b1;
                        state_q  <= S_ERRO;
                    end else if (addr_q != limit_q) begin
                        state_q <= S_PROXIMO;
                    end else if (limit_q == LAST_ADDR) begin
                        pronto_q  <= 1'b1;
                        acertou_q <= 1'b1;
                        state_q   <= S_ACERTO;
                    end else begin
                        state_q <= S_PROXIMA_RODADA;
                    end
                end
                S_PROXIMO: begin
                    addr_q  <= addr_q + 1'b1;
`ifdef TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= S_ESPERA;
                end
                S_PROXIMA_RODADA: begin
                    limit_q <= limit_q + 1'b1;
                    addr_q  <= '0;
`ifdef TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                    state_q <= S_ESPERA;
                end
                // Terminal states keep address, limit and flags on display.
                S_ACERTO, S_ERRO, S_TIMEOUT: begin
                    if (iniciar) state_q <= S_PREPARA;
                end
                default: begin
                    state_q <= S_INICIAL;
                end
            endcase
        end
    end

    assign pronto      = pronto_q;
    assign acertou     = acertou_q;
    assign errou       = errou_q;
    assign db_contagem = addr_q;
    assign db_limite   = limit_q;
    assign db_chaves   = key_q;
    assign db_memoria  = rom_q;
    assign db_estado   = state_q;
`ifdef TIMEOUT_EN
    assign db_timeout  = tmo_flag_q;
`else
    assign db_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_match_datapath.sv
// -----------------------------------------------------------------------------
// tb_seq_match_datapath
//
// Game-level reference: the player's remaining sequence for the current round
// is kept in exp_q; the expected outputs follow from the round number, the
// position in the round, the last key and the game status.
// -----------------------------------------------------------------------------
module tb_seq_match_datapath;

    localparam int DW    = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    localparam int ST_IDLE = 0;
    localparam int ST_PLAY = 1;
    localparam int ST_WIN  = 2;
    localparam int ST_ERR  = 3;
    localparam int ST_TMO  = 4;

    // ---------------- clock / reset ----------------
    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          iniciar = 1'b0;
    logic [DW-1:0] chaves  = '0;
    logic          pronto, acertou, errou, db_timeout;
    logic [AW-1:0] db_contagem, db_limite;
    logic [DW-1:0] db_chaves, db_memoria;
    logic [3:0]    db_estado;

    always #5 clock = ~clock;

    seq_match_datapath #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(100)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .pronto(pronto), .acertou(acertou), .errou(errou),
        .db_contagem(db_contagem), .db_limite(db_limite), .db_chaves(db_chaves),
        .db_memoria(db_memoria), .db_estado(db_estado), .db_timeout(db_timeout)
    );

    // ---------------- scoreboard / model ----------------
    int            n_vec = 0;
    int            n_err = 0;
    bit            check_en = 1'b0;
    int            m_status = ST_IDLE;
    int            m_round  = 0;
    int            m_pos    = 0;
    logic [DW-1:0] m_key    = '0;
    logic [DW-1:0] exp_q[$];

    function automatic logic [DW-1:0] word(input int i);
        return DW'(1) << (i % DW);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void refill();
        exp_q.delete();
        for (int i = 0; i <= m_round; i++) exp_q.push_back(word(i));
    endfunction

    function automatic void model_reset();
        m_status = ST_IDLE; m_round = 0; m_pos = 0; m_key = '0;
        exp_q.delete();
    endfunction

    function automatic void model_start();
        m_status = ST_PLAY; m_round = 0; m_pos = 0; m_key = '0;
        refill();
    endfunction

    function automatic void model_play(input logic [DW-1:0] v);
        if (m_status != ST_PLAY) return;
        m_key = v;
        if (v == exp_q[0]) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
                if (m_round == DEPTH - 1) begin
                    m_status = ST_WIN;
                end else begin
                    m_round = m_round + 1;
                    m_pos   = 0;
                    refill();
                end
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            m_status = ST_ERR;
        end
    endfunction

    function automatic int exp_state();
        case (m_status)
            ST_PLAY: return 2;
            ST_WIN:  return 6;
            ST_ERR:  return 7;
            ST_TMO:  return 8;
            default: return 0;
        endcase
    endfunction

    // Compare process: every cycle the game is settled.
    always @(negedge clock) begin
        if (check_en) begin
            chk("cyc_estado",   32'(db_estado),   32'(exp_state()));
            chk("cyc_contagem", 32'(db_contagem), 32'(m_pos));
            chk("cyc_limite",   32'(db_limite),   32'(m_round));
            chk("cyc_chaves",   32'(db_chaves),   32'(m_key));
            chk("cyc_memoria",  32'(db_memoria),  32'(word(m_pos)));
            chk("cyc_pronto",   32'(pronto),      32'(m_status >= ST_WIN));
            chk("cyc_acertou",  32'(acertou),     32'(m_status == ST_WIN));
            chk("cyc_errou",    32'(errou),       32'(m_status >= ST_ERR));
            chk("cyc_timeout",  32'(db_timeout),  32'(m_status == ST_TMO));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_game();
        check_en = 1'b0;
        @(posedge clock); #1 iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        model_start();
        check_en = 1'b1;
    endtask

    // Press v, optionally slide to v2 (non-zero) without releasing, hold, release.
    task automatic play(input logic [DW-1:0] v, input int hold,
                        input logic [DW-1:0] v2, input int rel);
        check_en = 1'b0;
        @(posedge clock); #1 chaves = v;
        model_play(v);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (i == 0 && v2 != '0) chaves = v2;
        end
        check_en = 1'b1;
        repeat (hold) begin @(posedge clock); #1; end
        chaves = '0;
        repeat (rel) begin @(posedge clock); #1; end
    endtask

    task automatic pulse_iniciar();
        @(posedge clock); #1 iniciar = 1'b1;
        @(posedge clock); #1 iniciar = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] v, v2;
        int steps;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_estado",   32'(db_estado),   32'd0);
        chk("rst_contagem", 32'(db_contagem), 32'd0);
        chk("rst_limite",   32'(db_limite),   32'd0);
        chk("rst_chaves",   32'(db_chaves),   32'd0);
        chk("rst_pronto",   32'(pronto),      32'd0);
        chk("rst_acertou",  32'(acertou),     32'd0);
        chk("rst_errou",    32'(errou),       32'd0);
        chk("rst_timeout",  32'(db_timeout),  32'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_memoria_w0", 32'(db_memoria), 32'd1);
        model_reset();
        check_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Full win: 1 | 1,2 | 1,2,4 | 1,2,4,8
        start_game();
        for (int r = 0; r < DEPTH; r++)
            for (int i = 0; i <= r; i++)
                play(word(i), 1, '0, 2);
        @(negedge clock);
        chk("win_pronto",  32'(pronto),    32'd1);
        chk("win_acertou", 32'(acertou),   32'd1);
        chk("win_errou",   32'(errou),     32'd0);
        chk("win_limite",  32'(db_limite), 32'd3);
        chk("win_estado",  32'(db_estado), 32'd6);

        // Error in round 1: 1, 1, 4
        start_game();
        play(4'd1, 1, '0, 2);
        play(4'd1, 1, '0, 2);
        play(4'd4, 1, '0, 2);
        @(negedge clock);
        chk("err_errou",    32'(errou),       32'd1);
        chk("err_pronto",   32'(pronto),      32'd1);
        chk("err_contagem", 32'(db_contagem), 32'd1);
        chk("err_memoria",  32'(db_memoria),  32'd2);
        chk("err_chaves",   32'(db_chaves),   32'd4);
        chk("err_estado",   32'(db_estado),   32'd7);
        check_en = 1'b0;
        pulse_iniciar();
        @(negedge clock);
        chk("restart_estado1", 32'(db_estado), 32'd1);
        @(negedge clock);
        chk("restart_estado2", 32'(db_estado), 32'd2);
        chk("restart_errou",   32'(errou),     32'd0);
        chk("restart_pronto",  32'(pronto),    32'd0);
        @(posedge clock); #1;
        model_start();
        check_en = 1'b1;

        // Held key for 20 cycles counts once, then a slide 1->2 is no play
        play(4'd1, 16, '0, 2);
        @(negedge clock);
        chk("held_limite",   32'(db_limite),   32'd1);
        chk("held_contagem", 32'(db_contagem), 32'd0);
        play(4'd1, 3, 4'd2, 2);
        @(negedge clock);
        chk("slide_contagem", 32'(db_contagem), 32'd1);
        chk("slide_limite",   32'(db_limite),   32'd1);
        chk("slide_chaves",   32'(db_chaves),   32'd1);
        play(4'd2, 1, '0, 2);

        // Asynchronous reset between edges while in ESPERA of round 2
        check_en = 1'b0;
        @(posedge clock); #2 reset = 1'b1;
        #1;
        chk("async_estado", 32'(db_estado), 32'd0);
        chk("async_limite", 32'(db_limite), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        @(posedge clock); #1;
        check_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // No play after start
        start_game();
`ifdef TIMEOUT_EN
        check_en = 1'b0;
        repeat (110) @(posedge clock);
        @(negedge clock);
        chk("tmo_estado",  32'(db_estado),  32'd8);
        chk("tmo_errou",   32'(errou),      32'd1);
        chk("tmo_timeout", 32'(db_timeout), 32'd1);
        m_status = ST_TMO;
        check_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
`else
        repeat (120) @(posedge clock);
        @(negedge clock);
        chk("idle_estado",  32'(db_estado),  32'd2);
        chk("idle_timeout", 32'(db_timeout), 32'd0);
`endif

        // Randomized games
        for (int g = 0; g < 25; g++) begin
            start_game();
            steps = 0;
            while (m_status == ST_PLAY && steps < 12) begin
                v = exp_q[0];
                if ($urandom_range(0, 11) == 0) begin
                    do v = DW'($urandom_range(1, (1 << DW) - 1)); while (v == exp_q[0]);
                end
                v2 = ($urandom_range(0, 5) == 0) ? DW'($urandom_range(1, (1 << DW) - 1)) : '0;
                play(v, $urandom_range(0, 3), v2, $urandom_range(1, 4));
                if (m_status == ST_PLAY && $urandom_range(0, 7) == 0) pulse_iniciar();
                steps++;
            end
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
        end

        check_en = 1'b0;
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_match_datapath.md
Name: seq_match_datapath

Overview:
Parametrised successor of the experiment-3 data flow: sequence ROM, address counter, key register and equality comparator. Adds a round-limit counter and an integrated control FSM, which turns the block into a self-contained "repeat the growing sequence" engine. Round k requires the player to enter ROM words 0..k in order. Sits under the top-level board wrapper; debug outputs drive the 7-segment displays.

Parameters:
DATA_WIDTH, 4, width of keys and ROM words
ADDR_WIDTH, 2, ROM address width; DEPTH = 2**ADDR_WIDTH words, rounds 0..DEPTH-1
TIMEOUT_CYCLES, 100, idle cycles allowed in ESPERA (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces INICIAL and clears all registers
iniciar  in  1  start/restart request, level-sampled
chaves  in  DATA_WIDTH  player keys, one-hot in normal use
pronto  out  1  game finished (win, error or timeout)
acertou  out  1  whole sequence completed
errou  out  1  mismatch or timeout
db_contagem  out  ADDR_WIDTH  current ROM address
db_limite  out  ADDR_WIDTH  current round limit
db_chaves  out  DATA_WIDTH  registered key value
db_memoria  out  DATA_WIDTH  current ROM word
db_estado  out  4  FSM state code
db_timeout  out  1  timeout flag

Behaviour:
- Reset: state is INICIAL (0). Address, limit and key register are 0. All flags are 0. db_memoria shows ROM word 0 from the first clock edge after reset release.
- ROM is synchronous with 1-cycle read latency. Word i = 1 << (i mod DATA_WIDTH), so with DATA_WIDTH=4 the contents are 1,2,4,8,...
- Play detect: a 1-cycle registered edge. jogada = (chaves != 0) AND (previous-cycle chaves == 0). Keys held for many cycles count as one play. Key changes with no intervening zero are ignored.
- Comparator: unsigned equality of the key register and the ROM word, full DATA_WIDTH.
- FSM state codes:
  - 0 INICIAL: on iniciar go to 1.
  - 1 PREPARA: clear address, limit, key register and flags; go to 2.
  - 2 ESPERA: on jogada, load chaves into the key register and go to 3.
  - 3 COMPARA:
    - mismatch: go to 7.
    - match and address != limit: go to 4.
    - match and address == limit and limit == DEPTH-1: go to 6.
    - match and address == limit otherwise: go to 5.
  - 4 PROXIMO: address+1; go to 2.
  - 5 PROXIMA_RODADA: limit+1, address=0; go to 2.
  - 6 ACERTO: pronto=1, acertou=1. Hold; on iniciar go to 1.
  - 7 ERRO: pronto=1, errou=1. Hold; on iniciar go to 1.
  - 8 TIMEOUT: only with the macro; pronto=1, errou=1, db_timeout=1. On iniciar go to 1.
- Flags are registered. They assert on entry to states 6/7/8 and stay asserted until PREPARA clears them.
- Counters never wrap in operation; the limit stops at DEPTH-1. Address and limit hold their values in states 6/7/8 for display.
- ROM timing: ESPERA always lasts at least 1 cycle after an address change, so the ROM word is valid in COMPARA.
- iniciar is ignored in states 1-5.
- reset asserted at any time returns to INICIAL immediately, without waiting for a clock edge.
- Unused state codes (9-15) go to INICIAL.

Optional Feature:
TIMEOUT_EN
- Defined: a timeout counter sized for TIMEOUT_CYCLES clears on entry to ESPERA and on every jogada, and increments each cycle spent in ESPERA. When it reaches TIMEOUT_CYCLES with no jogada, go to TIMEOUT (8). jogada takes priority when both occur in the same cycle.
- Not defined: no counter is built, state 8 is unreachable, db_timeout is tied to 0, and ESPERA waits forever.

Test Plan:
- Reset: pulse reset -> all flags 0, db_estado=0, db_contagem=0, db_limite=0, db_chaves=0.
- Full win (DATA_WIDTH=4, ADDR_WIDTH=2): iniciar, then plays 1 | 1,2 | 1,2,4 | 1,2,4,8, each followed by release to 0 -> after the 10th play pronto=1, acertou=1, errou=0, db_limite=3, db_estado=6.
- Error in round 1: plays 1, 1, 4 -> errou=1, pronto=1, db_contagem=1, db_memoria=2, db_chaves=4, db_estado=7. A later iniciar -> state 1, then 2 with flags cleared.
- Held key: chaves=1 held for 20 cycles during round 0 -> exactly one comparison, and the FSM advances to round 1 (db_limite=1). A change from 1 to 2 without a release -> no play.
- Async reset mid-game: in ESPERA during round 2, assert reset between clock edges -> db_estado=0 and db_limite=0 before the next rising edge.
- TIMEOUT_EN, TIMEOUT_CYCLES=100: no play after iniciar -> 100 cycles later errou=1, db_timeout=1, db_estado=8. Same stimulus without the macro -> db_estado stays 2 and db_timeout=0.
